// File: rtl/network_bank_ctrl.sv
// network_bank_ctrl: stage/address sequencer for the 16-bank NTT coefficient memory and crossbar,
// with a stall-aware delay line that replays each read beat as the write-back beat.
module network_bank_ctrl #(
  parameter int addr_width = 6,
  parameter int NUM_STAGE  = 10,
  parameter int BFU_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inv,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            stage,
  output logic                  rd_en,
  output logic [addr_width-1:0] b0, b1, b2, b3, b4, b5, b6, b7,
  output logic [addr_width-1:0] b8, b9, b10, b11, b12, b13, b14, b15,
  output logic [3:0]            sel_a_0, sel_a_1, sel_a_2, sel_a_3, sel_a_4, sel_a_5, sel_a_6, sel_a_7,
  output logic [3:0]            sel_a_8, sel_a_9, sel_a_10, sel_a_11, sel_a_12, sel_a_13, sel_a_14, sel_a_15,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_b0, wr_b1, wr_b2, wr_b3, wr_b4, wr_b5, wr_b6, wr_b7,
  output logic [addr_width-1:0] wr_b8, wr_b9, wr_b10, wr_b11, wr_b12, wr_b13, wr_b14, wr_b15,
  output logic [3:0]            wr_sel_a_0, wr_sel_a_1, wr_sel_a_2, wr_sel_a_3,
  output logic [3:0]            wr_sel_a_4, wr_sel_a_5, wr_sel_a_6, wr_sel_a_7,
  output logic [3:0]            wr_sel_a_8, wr_sel_a_9, wr_sel_a_10, wr_sel_a_11,
  output logic [3:0]            wr_sel_a_12, wr_sel_a_13, wr_sel_a_14, wr_sel_a_15
);
  localparam int AW = addr_width;
  localparam int CW = $clog2(BFU_LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;
  typedef struct packed {
    logic                 v;
    logic [15:0][AW-1:0]  b;
    logic [15:0][3:0]     sel;
  } beat_t;
  state_t                    st_q, st_d;
  logic [AW-1:0]             c_q, c_d;
  logic [3:0]                s_q, s_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      inv_q, inv_d;
  logic                      busy_q, busy_d, done_q, done_d, live_q;
  logic [3:0]                p;
  logic [AW-1:0]             flip;
  beat_t                     rd_q, rd_d;
  beat_t [BFU_LAT-1:0]       dl_q, dl_d;
  always_comb begin
    st_d   = st_q;
    c_d    = c_q;
    s_d    = s_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    done_d = 1'b0;
    if (!stall) begin
      case (st_q)
        IDLE: if (start) begin
          st_d  = RUN;
          c_d   = '0;
          s_d   = '0;
          inv_d = inv;
        end
        RUN: if (c_q == '1) begin
          st_d  = (s_q == 4'(NUM_STAGE - 1)) ? DRAIN : GAP;
          cnt_d = '0;
        end else c_d = c_q + 1'b1;
        default: if (cnt_q != CW'(BFU_LAT - 1)) cnt_d = cnt_q + 1'b1;
          else if (st_q == GAP) begin
            st_d = RUN;
            s_d  = s_q + 4'd1;
            c_d  = '0;
          end else begin
            st_d   = IDLE;
            done_d = 1'b1;
          end
      endcase
    end
    busy_d = st_d != IDLE;
    p      = inv_d ? 4'(NUM_STAGE - 1) - s_d : s_d;
    flip   = (p >= 4'd4) ? AW'(1) << (32'(p - 4'd4) % AW) : '0;
    // Payload holds outside RUN/GAP/DRAIN so idle outputs keep their last (or reset) value.
    rd_d = rd_q;
    if (!stall) rd_d.v = st_d == RUN;
    if (!stall && busy_d)
      for (int j = 0; j < 16; j++) begin
        rd_d.sel[j] = 4'(j) ^ (4'd1 << p[1:0]);
        rd_d.b[j]   = (j % 2 == 1) ? c_d ^ flip : c_d;
      end
    dl_d[0] = stall ? dl_q[0] : rd_q;
    for (int k = 1; k < BFU_LAT; k++) dl_d[k] = stall ? dl_q[k] : dl_q[k-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      c_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      live_q <= 1'b0;
      rd_q   <= '0;
      dl_q   <= '0;
    end else begin
      st_q   <= st_d;
      c_q    <= c_d;
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      live_q <= ~stall;
      rd_q   <= rd_d;
      dl_q   <= dl_d;
    end
  end
  // A stalled edge clears live_q, masking both enables for the following cycle.
  assign rd_en = rd_q.v & live_q;
  assign wr_en = dl_q[BFU_LAT-1].v & live_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stage = s_q;
  assign {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0} = rd_q.b;
  assign {sel_a_15, sel_a_14, sel_a_13, sel_a_12, sel_a_11, sel_a_10, sel_a_9, sel_a_8,
          sel_a_7, sel_a_6, sel_a_5, sel_a_4, sel_a_3, sel_a_2, sel_a_1, sel_a_0} = rd_q.sel;
  assign {wr_b15, wr_b14, wr_b13, wr_b12, wr_b11, wr_b10, wr_b9, wr_b8,
          wr_b7, wr_b6, wr_b5, wr_b4, wr_b3, wr_b2, wr_b1, wr_b0} = dl_q[BFU_LAT-1].b;
  assign {wr_sel_a_15, wr_sel_a_14, wr_sel_a_13, wr_sel_a_12, wr_sel_a_11, wr_sel_a_10, wr_sel_a_9, wr_sel_a_8,
          wr_sel_a_7, wr_sel_a_6, wr_sel_a_5, wr_sel_a_4, wr_sel_a_3, wr_sel_a_2, wr_sel_a_1, wr_sel_a_0} = dl_q[BFU_LAT-1].sel;
endmodule

// File: tb/tb_network_bank_ctrl.sv
// tb_network_bank_ctrl: checkpoint tables per scenario plus a per-cycle write-back/permutation monitor.
module tb_network_bank_ctrl;
  logic clk = 1'b0, rst, start, inv, stall;
  logic busy, done, rd_en, wr_en;
  logic [3:0] stage;
  logic [5:0] b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15;
  logic [5:0] wr_b0, wr_b1, wr_b2, wr_b3, wr_b4, wr_b5, wr_b6, wr_b7;
  logic [5:0] wr_b8, wr_b9, wr_b10, wr_b11, wr_b12, wr_b13, wr_b14, wr_b15;
  logic [3:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3, sel_a_4, sel_a_5, sel_a_6, sel_a_7;
  logic [3:0] sel_a_8, sel_a_9, sel_a_10, sel_a_11, sel_a_12, sel_a_13, sel_a_14, sel_a_15;
  logic [3:0] wr_sel_a_0, wr_sel_a_1, wr_sel_a_2, wr_sel_a_3, wr_sel_a_4, wr_sel_a_5, wr_sel_a_6, wr_sel_a_7;
  logic [3:0] wr_sel_a_8, wr_sel_a_9, wr_sel_a_10, wr_sel_a_11, wr_sel_a_12, wr_sel_a_13, wr_sel_a_14, wr_sel_a_15;

  network_bank_ctrl #(.addr_width(6), .NUM_STAGE(10), .BFU_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .stall(stall),
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
    .b8(b8), .b9(b9), .b10(b10), .b11(b11), .b12(b12), .b13(b13), .b14(b14), .b15(b15),
    .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
    .sel_a_4(sel_a_4), .sel_a_5(sel_a_5), .sel_a_6(sel_a_6), .sel_a_7(sel_a_7),
    .sel_a_8(sel_a_8), .sel_a_9(sel_a_9), .sel_a_10(sel_a_10), .sel_a_11(sel_a_11),
    .sel_a_12(sel_a_12), .sel_a_13(sel_a_13), .sel_a_14(sel_a_14), .sel_a_15(sel_a_15),
    .wr_en(wr_en),
    .wr_b0(wr_b0), .wr_b1(wr_b1), .wr_b2(wr_b2), .wr_b3(wr_b3), .wr_b4(wr_b4), .wr_b5(wr_b5),
    .wr_b6(wr_b6), .wr_b7(wr_b7), .wr_b8(wr_b8), .wr_b9(wr_b9), .wr_b10(wr_b10), .wr_b11(wr_b11),
    .wr_b12(wr_b12), .wr_b13(wr_b13), .wr_b14(wr_b14), .wr_b15(wr_b15),
    .wr_sel_a_0(wr_sel_a_0), .wr_sel_a_1(wr_sel_a_1), .wr_sel_a_2(wr_sel_a_2), .wr_sel_a_3(wr_sel_a_3),
    .wr_sel_a_4(wr_sel_a_4), .wr_sel_a_5(wr_sel_a_5), .wr_sel_a_6(wr_sel_a_6), .wr_sel_a_7(wr_sel_a_7),
    .wr_sel_a_8(wr_sel_a_8), .wr_sel_a_9(wr_sel_a_9), .wr_sel_a_10(wr_sel_a_10), .wr_sel_a_11(wr_sel_a_11),
    .wr_sel_a_12(wr_sel_a_12), .wr_sel_a_13(wr_sel_a_13), .wr_sel_a_14(wr_sel_a_14), .wr_sel_a_15(wr_sel_a_15)
  );

  always #5 clk = ~clk;

  wire [95:0] rb = {b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
  wire [63:0] rs = {sel_a_15, sel_a_14, sel_a_13, sel_a_12, sel_a_11, sel_a_10, sel_a_9, sel_a_8,
                    sel_a_7, sel_a_6, sel_a_5, sel_a_4, sel_a_3, sel_a_2, sel_a_1, sel_a_0};
  wire [95:0] wb = {wr_b15, wr_b14, wr_b13, wr_b12, wr_b11, wr_b10, wr_b9, wr_b8,
                    wr_b7, wr_b6, wr_b5, wr_b4, wr_b3, wr_b2, wr_b1, wr_b0};
  wire [63:0] ws = {wr_sel_a_15, wr_sel_a_14, wr_sel_a_13, wr_sel_a_12, wr_sel_a_11, wr_sel_a_10, wr_sel_a_9, wr_sel_a_8,
                    wr_sel_a_7, wr_sel_a_6, wr_sel_a_5, wr_sel_a_4, wr_sel_a_3, wr_sel_a_2, wr_sel_a_1, wr_sel_a_0};

  typedef struct {
    int cyc;
    bit start, stall, rst;
    bit rd, busy, done;
    logic [3:0] stg;
    logic [95:0] b;
    logic [63:0] s;
  } vec_t;

  typedef struct packed {
    logic v;
    logic [95:0] b;
    logic [63:0] s;
  } beat_t;

  vec_t tbl[$];
  int nchk = 0, nfail = 0;
  int cyc = 0, nrd, nwr, ndone, done_cyc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs: odd banks get c^fl, crossbar j -> j^m; m<0 means all-zero outputs.
  function automatic vec_t mk(int cy, bit st, bit sl, bit r, bit rd, bit by, bit dn,
                              int sg, int c, int fl, int m);
    vec_t v;
    v.cyc = cy; v.start = st; v.stall = sl; v.rst = r;
    v.rd = rd; v.busy = by; v.done = dn; v.stg = 4'(sg);
    for (int k = 0; k < 16; k++) begin
      v.b[k*6 +: 6] = (m < 0) ? 6'd0 : (k % 2 == 1) ? 6'(c ^ fl) : 6'(c);
      v.s[k*4 +: 4] = (m < 0) ? 4'd0 : 4'(k ^ m);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_en) nrd++;
    if (wr_en) nwr++;
    if (done) begin ndone++; done_cyc = cyc; end
  endtask

  // start is driven in cycle 0; table entries are checked at their cycle and then drive that cycle's inputs.
  task automatic run(input bit iv, input int last);
    int k = 0;
    cyc = 0; nrd = 0; nwr = 0; ndone = 0; done_cyc = -1;
    inv = iv; start = 1'b1; stall = 1'b0; rst = 1'b0;
    while (cyc < last) begin
      tick();
      start = 1'b0; stall = 1'b0; rst = 1'b0; inv = ~iv;
      if (k < tbl.size() && tbl[k].cyc == cyc) begin
        chk("rd_en", rd_en, tbl[k].rd);
        chk("busy", busy, tbl[k].busy);
        chk("done", done, tbl[k].done);
        chk("stage", stage, tbl[k].stg);
        chk("rd_addr", rb, tbl[k].b);
        chk("rd_sel", rs, tbl[k].s);
        start = tbl[k].start; stall = tbl[k].stall; rst = tbl[k].rst;
        k++;
      end
    end
  endtask

  task automatic fill_fwd();
    tbl.delete();
    tbl.push_back(mk(1,   0, 0, 0, 1, 1, 0, 0, 0,  0,  1));
    tbl.push_back(mk(64,  0, 0, 0, 1, 1, 0, 0, 63, 0,  1));
    tbl.push_back(mk(65,  0, 0, 0, 0, 1, 0, 0, 63, 0,  1));
    tbl.push_back(mk(68,  0, 0, 0, 0, 1, 0, 0, 63, 0,  1));
    tbl.push_back(mk(69,  0, 0, 0, 1, 1, 0, 1, 0,  0,  2));
    tbl.push_back(mk(278, 0, 0, 0, 1, 1, 0, 4, 5,  1,  1));
    tbl.push_back(mk(345, 0, 0, 0, 1, 1, 0, 5, 4,  2,  2));
    tbl.push_back(mk(676, 0, 0, 0, 1, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(677, 0, 0, 0, 0, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(680, 0, 0, 0, 0, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(681, 0, 0, 0, 0, 0, 1, 9, 63, 32, 2));
    tbl.push_back(mk(682, 0, 0, 0, 0, 0, 0, 9, 63, 32, 2));
  endtask

  task automatic totals(input int exp_done);
    chk("n_rd", nrd, 640);
    chk("n_wr", nwr, 640);
    chk("n_done", ndone, 1);
    chk("done_cyc", done_cyc, exp_done);
  endtask

  // Monitor: every write-back beat must match a read beat from exactly 4 unstalled edges earlier.
  initial begin : mon
    beat_t hist[4];
    beat_t pend;
    bit stl, rr, ew;
    int mask;
    pend = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      stl = stall; rr = rst;
      if (rr) begin
        for (int i = 0; i < 4; i++) hist[i] = '0;
        pend = '0;
      end else if (!stl) begin
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pend;
        pend = '0;
      end
      #1;
      ew = !rr && !stl && hist[3].v;
      chk("wr_en", wr_en, ew);
      if (ew) begin
        chk("wr_addr", wb, hist[3].b);
        chk("wr_sel", ws, hist[3].s);
      end
      if (rd_en) begin
        pend = {1'b1, rb, rs};
        mask = 0;
        for (int j = 0; j < 16; j++) mask |= 1 << rs[j*4 +: 4];
        chk("sel_perm", mask, 32'hFFFF);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; inv = 1'b0; stall = 1'b0;
    repeat (3) tick();
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stage", stage, 4'd0);
    chk("rst_addr", {rb, wb}, '0);
    chk("rst_sel", {rs, ws}, '0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_sel", rs, '0);

    fill_fwd();
    run(1'b0, 685);
    totals(681);

    tbl.delete();
    tbl.push_back(mk(1,   0, 0, 0, 1, 1, 0, 0, 0,  32, 2));
    tbl.push_back(mk(6,   0, 0, 0, 1, 1, 0, 0, 5,  32, 2));
    tbl.push_back(mk(65,  0, 0, 0, 0, 1, 0, 0, 63, 32, 2));
    tbl.push_back(mk(69,  0, 0, 0, 1, 1, 0, 1, 0,  16, 1));
    tbl.push_back(mk(343, 0, 0, 0, 1, 1, 0, 5, 2,  1,  1));
    tbl.push_back(mk(613, 0, 0, 0, 1, 1, 0, 9, 0,  0,  1));
    tbl.push_back(mk(676, 0, 0, 0, 1, 1, 0, 9, 63, 0,  1));
    tbl.push_back(mk(681, 0, 0, 0, 0, 0, 1, 9, 63, 0,  1));
    run(1'b1, 685);
    totals(681);

    tbl.delete();
    tbl.push_back(mk(137, 0, 0, 0, 1, 1, 0, 2, 0,  0,  4));
    tbl.push_back(mk(147, 0, 1, 0, 1, 1, 0, 2, 10, 0,  4));
    tbl.push_back(mk(148, 0, 1, 0, 0, 1, 0, 2, 10, 0,  4));
    tbl.push_back(mk(149, 0, 1, 0, 0, 1, 0, 2, 10, 0,  4));
    tbl.push_back(mk(150, 0, 0, 0, 0, 1, 0, 2, 10, 0,  4));
    tbl.push_back(mk(151, 0, 0, 0, 1, 1, 0, 2, 11, 0,  4));
    tbl.push_back(mk(152, 0, 0, 0, 1, 1, 0, 2, 12, 0,  4));
    tbl.push_back(mk(679, 0, 0, 0, 1, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(680, 0, 0, 0, 0, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(683, 0, 0, 0, 0, 1, 0, 9, 63, 32, 2));
    tbl.push_back(mk(684, 0, 0, 0, 0, 0, 1, 9, 63, 32, 2));
    run(1'b0, 688);
    totals(684);

    tbl.delete();
    tbl.push_back(mk(300, 0, 0, 1, 1, 1, 0, 4, 27, 1, 1));
    tbl.push_back(mk(301, 0, 0, 0, 0, 0, 0, 0, 0,  0, -1));
    tbl.push_back(mk(305, 0, 0, 0, 0, 0, 0, 0, 0,  0, -1));
    run(1'b0, 310);
    chk("rst_no_done", ndone, 0);
    chk("rst_wr_en", wr_en, 1'b0);

    fill_fwd();
    run(1'b0, 685);
    totals(681);

    tbl.delete();
    tbl.push_back(mk(50,  1, 0, 0, 1, 1, 0, 0, 49, 0,  1));
    tbl.push_back(mk(51,  0, 0, 0, 1, 1, 0, 0, 50, 0,  1));
    tbl.push_back(mk(400, 1, 0, 0, 1, 1, 0, 5, 59, 2,  2));
    tbl.push_back(mk(401, 0, 0, 0, 1, 1, 0, 5, 60, 2,  2));
    tbl.push_back(mk(681, 0, 0, 0, 0, 0, 1, 9, 63, 32, 2));
    run(1'b0, 685);
    totals(681);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/network_bank_ctrl.md
# network_bank_ctrl

Sequencer for the 16-bank coefficient memory and its bank-input crossbar in the radix-2, 8-BFU NTT core. On `start` it steps through every NTT stage. Each cycle it issues 16 per-bank read addresses and the 16 crossbar select codes that route bank words to BFU ports. It also produces a write-back copy of the same addresses and selects, delayed by the butterfly latency. It owns read/write sequencing only; coefficient data never passes through it.

## Interface
- `addr_width`, 6: per-bank address width; one stage = 2^addr_width read cycles (64).
- `NUM_STAGE`, 10: stages per transform (1..16).
- `BFU_LAT`, 4: read-to-write-back latency of the BFU pipeline (≥1); also the inter-stage gap.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin transform; sampled only in IDLE.
- `inv`  in  1  0 = NTT stage order, 1 = INTT (reversed); latched at `start`.
- `stall`  in  1  freeze all counters and the delay line this cycle.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse at end of transform.
- `stage`  out  4  current logical stage s.
- `rd_en`  out  1  read addresses/selects valid this cycle.
- `b0`..`b15`  out  addr_width each  per-bank read address.
- `sel_a_0`..`sel_a_15`  out  4 each  crossbar select for BFU port j.
- `wr_en`  out  1  write-back valid.
- `wr_b0`..`wr_b15`, `wr_sel_a_0`..`wr_sel_a_15`  out  as read side  write-back copies.

## Operation
- States:
  - IDLE: `start` → RUN, s=0, c=0.
  - RUN: c counts 0..2^addr_width−1 with `rd_en`=1.
    - At the last c: if s<NUM_STAGE−1 → GAP, else → DRAIN.
  - GAP: BFU_LAT cycles with `rd_en`=0, then s+1 → RUN, c=0.
  - DRAIN: BFU_LAT cycles, then IDLE with `done`=1 for one cycle.
- Physical stage p = `inv` ? NUM_STAGE−1−s : s.
- Mask m = 1 << (p mod 4), a 4-bit value.
- Select: `sel_a_j` = j XOR m. This is always a permutation of 0..15.
- Address for even k: `b_k` = c.
- Address for odd k:
  - p<4: `b_k` = c.
  - p≥4: `b_k` = c XOR (1 << ((p−4) mod addr_width)).
- Write delay line: BFU_LAT stages holding {`rd_en`, b0..b15, sel_a_0..15}.
  - Advances only when `stall`=0.
  - Its output drives the `wr_*` ports.
- Stall behaviour:
  - `stall`=1 freezes state, c, s, gap/drain counters and the delay line.
  - `rd_en` and `wr_en` are forced 0 for that cycle; address/select outputs hold.
- `start` while busy is ignored. `inv` is ignored except at `start`.
- `rst` at any time:
  - State → IDLE.
  - All counters, delay-line contents and outputs → 0.
  - Any in-flight transform is abandoned with no `done`.

## Timing
- All outputs are registered. Reset value of every output is 0, including `sel_a_*` and `wr_sel_a_*`.
- Without stall, with `start` sampled at edge 0:
  - Stage s reads occupy cycles 1+s·(2^addr_width+BFU_LAT) through that value + 2^addr_width−1.
  - `wr_en` equals `rd_en` delayed exactly BFU_LAT unstalled cycles, with identical address/select payload.
  - `done` falls in the cycle after the last `wr_en`.
  - Defaults: reads cycles 1..676; last write at 680; `done` at 681; `busy` cycles 1..680.
- Each stall cycle lengthens every later event by exactly one cycle.
- `stage` changes in the first RUN cycle of the new stage and holds through GAP.

## Test plan
- Reset, then `start`=1, `inv`=0, no stall:
  - `rd_en` high cycles 1–64 with b0=b1=0..63 and `sel_a_j`=j^1.
  - Reads resume at cycle 69 with `stage`=1 and `sel_a_0`=2.
  - `done` pulse at cycle 681; exactly 640 `rd_en` and 640 `wr_en` cycles.
- `inv`=1:
  - Stage 0 uses p=9: `sel_a_j`=j^2; at c=5, b1=5^32=37 and b0=5.
  - Final stage uses p=0: `sel_a_j`=j^1.
- Every cycle, check that {`sel_a_j`} is a permutation of 0..15 and that `wr_*` equals the read outputs from 4 unstalled cycles earlier.
- Stall held 3 cycles at c=10 of stage 2:
  - `rd_en`/`wr_en` low during the stall; c resumes at 10.
  - `done` shifts to cycle 684.
- `rst` at cycle 300:
  - Next cycle all outputs are 0 and the block is IDLE.
  - A new `start` reproduces the first test's timing exactly.
- `start` re-asserted at cycles 50 and 400: no effect; `done` still at 681.
